multi_ch_mem: RTL
=================

// Module: multi_ch_mem
// PURPOSE
//  Parametrised multi-channel successor to the single-port valid/ready memory.
//  NUM_CH requesters share one WIDTH x DEPTH array through a round-robin arbiter.
//  One transaction is serviced per cycle.
//  Array is named `mem` so benches can preload and dump it via $readmemh/$writememh.
// PARAMETERS
//  WIDTH      16              data width per word
//  DEPTH      64              words in array (need not be a power of 2)
//  ADDR_WIDTH $clog2(DEPTH)   address width
//  NUM_CH     4               requester channels (1..8)
// PORTS
//  clk    in   1                  clock; single clock domain
//  rst    in   1                  reset, synchronous, active-high
//  valid  in   NUM_CH             per-channel request valid
//  wr_rd  in   NUM_CH             per-channel 1=write, 0=read
//  addr   in   NUM_CH*ADDR_WIDTH  channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//  wdata  in   NUM_CH*WIDTH       channel c at [c*WIDTH +: WIDTH]
//  rdata  out  NUM_CH*WIDTH       per-channel read data; registered
//  ready  out  NUM_CH             per-channel completion pulse; registered
//  err    out  NUM_CH             out-of-range flag; valid when ready is high
// BEHAVIOUR
//  - Reset: ready=0, err=0, all rdata=0, rr_ptr=0. `mem` is NOT cleared.
//    Preloaded contents survive rst.
//  - Eligible(c) = valid[c] && !ready[c]. A channel in its ready cycle cannot be granted.
//  - Grant (cycle T, combinational):
//    first eligible channel searching rr_ptr, rr_ptr+1, ... mod NUM_CH.
//    No eligible channel: no grant, rr_ptr holds.
//  - Edge ending T, granted channel g:
//    - Write: mem[addr_g] <= wdata_g.
//    - Read: rdata_g <= mem[addr_g].
//    - ready[g] <= 1.
//    - rr_ptr <= (g+1) mod NUM_CH.
//  - Latency: ready[g] is high in T+1 only, a one-cycle pulse.
//    Read data is valid in T+1 and holds until g's next read completes.
//    Writes do not change rdata_g.
//  - Handshake: requester keeps valid, wr_rd, addr, wdata stable until ready.
//    It may present a new request in T+1; that request is granted in T+2 at the earliest.
//    Max throughput is 1 txn per 2 cycles per channel and 1 txn per cycle total.
//  - Dropping valid before ready is a protocol violation.
//    A write already committed stays committed, and the pending ready still pulses.
//  - Out of range (addr_g >= DEPTH):
//    - No write occurs; rdata_g <= 0.
//    - err[g] <= 1 with ready[g]; err clears with ready.
//    - In-range completion: err[g] <= 0.
//  - Same-address writes from two channels are serialised by grant order; the later grant wins.
//    A read granted after a write observes the written value (no bypass needed).
//  - rst asserted mid-operation:
//    - The write in the rst cycle is suppressed.
//    - Pending ready/err are cleared; rdata is zeroed.
//    - Writes committed on earlier edges persist.
//  - All index math is mod NUM_CH. No other state; no internal FIFO.
// STRUCTURE
//  - Package mcm_pkg: DEF_WIDTH, DEF_DEPTH, DEF_NUM_CH, and localparam typedef for channel index.
//  - Sub-module rr_arbiter #(N): request vector + rr_ptr in, one-hot grant + grant index out.
//    rr_arbiter is purely combinational; the pointer register stays in multi_ch_mem.
//  - Top level: unpack buses, eligibility mask, `mem` array, per-channel rdata/ready/err registers.
// TESTING
//  - Defaults. Reset 2 cycles, then ch0 writes addr 5 = 16'hBEEF, then ch0 reads addr 5.
//    Expect: ready[0] one cycle after each grant; rdata[0] = 16'hBEEF; err[0] = 0.
//  - All 4 channels valid at once, reading addrs 1..4 preloaded via $readmemh.
//    Expect: ready pulses in order 0,1,2,3 on consecutive cycles, each rdata matching the preload.
//  - rr_ptr=2 with ch0 and ch3 both valid.
//    Expect: ch3 granted first, then ch0; rr_ptr ends at 1.
//  - DEPTH=48; ch1 reads addr 50, then writes addr 50.
//    Expect: both return err[1]=1 with ready[1]; rdata[1] = 0; $writememh dump unchanged.
//  - ch0 and ch2 both write addr 9 (ch0 = 16'h1111, ch2 = 16'h2222) with rr_ptr=0.
//    Expect: ch1 reads addr 9 afterwards and gets 16'h2222.
//  - Assert rst in the same cycle ch0 write addr 7 = 16'h00AA is granted.
//    Expect: mem[7] unchanged, ready=0 next cycle, rr_ptr=0; earlier-written words intact.

Source files
------------

// File: rtl/mcm_pkg.sv
// Shared definitions for the multi-channel memory.
//   DEF_WIDTH / DEF_DEPTH / DEF_NUM_CH : default parameter values for multi_ch_mem
//   MAX_CH / CH_IDX_W / ch_idx_t       : channel index type, wide enough for up to 8 channels
package mcm_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_NUM_CH = 4;

  localparam int MAX_CH   = 8;
  localparam int CH_IDX_W = 3;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/multi_ch_mem_rr_arbiter.sv
// Combinational round-robin arbiter. Searches ptr_i, ptr_i+1, ... (mod N) and
// grants the first requester found. The pointer register lives in the parent.
//   req_i       : request vector, one bit per channel
//   ptr_i       : channel with highest priority this cycle (must be < N)
//   gnt_o       : one-hot grant (all zero when nothing is requested)
//   gnt_idx_o   : index of the granted channel (0 when no grant)
//   gnt_valid_o : a grant was issued
module rr_arbiter
  import mcm_pkg::*;
#(
  parameter int N = DEF_NUM_CH
) (
  input  logic [N-1:0] req_i,
  input  ch_idx_t      ptr_i,
  output logic [N-1:0] gnt_o,
  output ch_idx_t      gnt_idx_o,
  output logic         gnt_valid_o
);

  // Padding to MAX_CH lets the 3-bit index select a request bit for any N.
  logic [MAX_CH-1:0]   req_pad;
  logic [CH_IDX_W:0]   cand;

  assign req_pad = MAX_CH'(req_i);

  always_comb begin
    cand        = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      // ptr_i < N and k < N, so one subtraction is enough for the wrap.
      cand = {1'b0, ptr_i} + (CH_IDX_W+1)'(k);
      if (cand >= (CH_IDX_W+1)'(N)) begin
        cand = cand - (CH_IDX_W+1)'(N);
      end
      if (!gnt_valid_o && req_pad[cand[CH_IDX_W-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand[CH_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int c = 0; c < N; c++) begin
      gnt_o[c] = gnt_valid_o && (gnt_idx_o == ch_idx_t'(c));
    end
  end

endmodule

// File: rtl/multi_ch_mem.sv
// NUM_CH requesters share one WIDTH x DEPTH array through a round-robin
// arbiter; one transaction is serviced per cycle.
//   clk, rst : single clock, synchronous active-high reset
//   valid    : per-channel request valid
//   wr_rd    : per-channel 1=write, 0=read
//   addr     : channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata    : channel c at [c*WIDTH +: WIDTH]
//   rdata    : per-channel registered read data, held until that channel's next read
//   ready    : per-channel one-cycle completion pulse
//   err      : out-of-range flag, meaningful while ready is high
// The array `mem` is not reset so preloaded contents survive rst.
module multi_ch_mem
  import mcm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_CH     = DEF_NUM_CH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            valid,
  input  logic [NUM_CH-1:0]            wr_rd,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*WIDTH-1:0]      wdata,
  output logic [NUM_CH*WIDTH-1:0]      rdata,
  output logic [NUM_CH-1:0]            ready,
  output logic [NUM_CH-1:0]            err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [NUM_CH-1:0]            elig;
  logic [NUM_CH-1:0]            gnt;
  ch_idx_t                      gnt_idx;
  logic                         gnt_any;

  logic [NUM_CH-1:0]            ready_q, ready_d;
  logic [NUM_CH-1:0]            err_q, err_d;
  logic [NUM_CH-1:0][WIDTH-1:0] rdata_q, rdata_d;
  ch_idx_t                      rr_ptr_q, rr_ptr_d;

  logic [ADDR_WIDTH-1:0]        sel_addr;
  logic [WIDTH-1:0]             sel_wdata;
  logic                         sel_wr;
  logic                         in_range;
  logic [WIDTH-1:0]             rd_word;
  logic                         do_write;

  // A channel in its ready cycle is masked so a held valid is not re-granted.
  assign elig = valid & ~ready_q;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req_i       (elig),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) begin
        sel_addr  = addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[c*WIDTH +: WIDTH];
        sel_wr    = wr_rd[c];
      end
    end
  end

  // Zero-extended compare so DEPTH need not be a power of two.
  assign in_range = ({1'b0, sel_addr} < DEPTH_L);
  assign rd_word  = in_range ? mem[sel_addr] : '0;
  assign do_write = gnt_any && sel_wr && in_range;

  always_comb begin
    ready_d  = gnt;
    err_d    = (gnt_any && !in_range) ? gnt : '0;
    rdata_d  = rdata_q;
    rr_ptr_d = rr_ptr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c] && !sel_wr) begin
        rdata_d[c] = rd_word;
      end
    end
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == ch_idx_t'(NUM_CH-1)) ? '0 : ch_idx_t'(gnt_idx + ch_idx_t'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // rst also blocks the write granted in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
